// File: rtl/mant_mult_seq.sv
// mant_mult_seq: radix-2 shift-and-add significand multiplier, one adder reused per cycle,
// exits early once the remaining multiplier bits are all zero.
module mant_mult_seq #(
  parameter int WIDTH = 24
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0]         r_state;
  logic [2*WIDTH-1:0] r_mcand;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_mplier;
  logic [CW-1:0]      r_count;
  logic [WIDTH-1:0]   w_mplier_nxt;
  logic               w_last;
  assign w_mplier_nxt = r_mplier >> 1;
  // the count bound is a backstop; the shifted multiplier empties by then anyway
  assign w_last = (w_mplier_nxt == '0) || (r_count == CW'(WIDTH - 1));
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state  <= IDLE;
      r_mcand  <= '0;
      r_acc    <= '0;
      r_mplier <= '0;
      r_count  <= '0;
    end else begin
      case (r_state)
        IDLE:
          if (in_valid) begin
            r_mcand  <= {{WIDTH{1'b0}}, a};
            r_mplier <= b;
            r_count  <= '0;
            r_acc    <= '0;
            r_state  <= (a == '0 || b == '0) ? DONE : RUN;
          end
        RUN: begin
          if (r_mplier[0]) r_acc <= r_acc + r_mcand;
          r_mcand  <= r_mcand << 1;
          r_mplier <= w_mplier_nxt;
          r_count  <= r_count + 1'b1;
          r_state  <= w_last ? DONE : RUN;
        end
        DONE:
          if (out_ready) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state == RUN);
  assign product   = r_acc;
endmodule

// File: tb/tb_mant_mult_seq.sv
// tb_mant_mult_seq: directed vector table plus backpressure and async-reset sequences.
module tb_mant_mult_seq;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [23:0] a = '0;
  logic [23:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [47:0] product;
  logic        busy;
  int checks = 0;
  int errors = 0;

  typedef struct {
    string       nm;
    logic [23:0] a;
    logic [23:0] b;
    logic [47:0] p;
    int          lat;
  } vec_t;
  vec_t v[8];

  mant_mult_seq #(.WIDTH(24)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .product(product), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_done(input string nm, input int lat, input logic [47:0] p);
    int n = 0;
    int nb = 0;
    while (!out_valid && n < 40) begin
      if (busy) nb++;
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk($sformatf("%s latency", nm), 64'(n), 64'(lat));
    chk($sformatf("%s busy cycles", nm), 64'(nb), 64'(lat));
    chk($sformatf("%s out_valid", nm), 64'(out_valid), 64'd1);
    chk($sformatf("%s in_ready in DONE", nm), 64'(in_ready), 64'd0);
    chk($sformatf("%s product", nm), 64'(product), 64'(p));
  endtask

  task automatic do_op(input string nm, input logic [23:0] ta, input logic [23:0] tb_,
                       input logic [47:0] p, input int lat);
    chk($sformatf("%s in_ready idle", nm), 64'(in_ready), 64'd1);
    a = ta;
    b = tb_;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a = 24'h5A5A5A;
    b = 24'hA5A5A5;
    wait_done(nm, lat, p);
    @(posedge clk);
    @(negedge clk);
    chk($sformatf("%s idle after handshake", nm), 64'({in_ready, out_valid, busy}), 64'b100);
  endtask

  initial begin
    v[0] = '{"normal", 24'h900000, 24'h980000, 48'h558000000000, 24};
    v[1] = '{"zero_a", 24'h000000, 24'h980000, 48'h0, 0};
    v[2] = '{"zero_b", 24'h000005, 24'h000000, 48'h0, 0};
    v[3] = '{"b_one", 24'hFFFFFF, 24'h000001, 48'h000000FFFFFF, 1};
    v[4] = '{"b_five", 24'hFFFFFF, 24'h000005, 48'h000004FFFFFB, 3};
    v[5] = '{"max", 24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001, 24};
    v[6] = '{"small", 24'h000003, 24'h000010, 48'h000000000030, 5};
    v[7] = '{"hidden", 24'h800000, 24'h000003, 48'h000000000000 | 48'h000001800000, 2};

    #12;
    chk("reset state", 64'({in_ready, out_valid, busy}), 64'b100);
    chk("reset product", 64'(product), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) do_op(v[i].nm, v[i].a, v[i].b, v[i].p, v[i].lat);

    a = 24'h000003;
    b = 24'h000003;
    in_valid = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    wait_done("bp", 2, 48'd9);
    for (int i = 0; i < 5; i++) begin
      a = 24'(i + 7);
      b = 24'(i + 2);
      @(posedge clk);
      @(negedge clk);
      chk("bp held", 64'({in_ready, out_valid, busy}), 64'b010);
      chk("bp product", 64'(product), 64'd9);
    end
    a = 24'h000007;
    b = 24'h000002;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp release idle", 64'({in_ready, out_valid, busy}), 64'b100);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp new accept", 64'(busy), 64'd1);
    wait_done("bp next", 2, 48'd14);
    @(posedge clk);
    @(negedge clk);

    a = 24'h800000;
    b = 24'hFFFFFF;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) @(posedge clk);
    #2;
    chk("pre-reset busy", 64'(busy), 64'd1);
    reset = 1'b1;
    #1;
    chk("async reset flags", 64'({in_ready, out_valid, busy}), 64'b100);
    chk("async reset product", 64'(product), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    do_op("after reset", 24'h800000, 24'h800000, 48'h400000000000, 24);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
